// File: rtl/dyn_slice_packer_if.sv
// Beat-in / word-out handshake bundle for the dynamic slice packer.
// Latency: none, wires only.
// Backpressure: in_ready and out_ready follow the usual valid/ready rules.
interface dyn_slice_packer_if #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int OFFW  = $clog2(WIDTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [SLICE-1:0] in_data;
    logic [OFFW-1:0]  in_off;
    logic             in_dir;
    logic             in_auto;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_mask;
    logic             out_clip;

    // Producer side: drives beats and consumes words.
    modport master (
        output in_valid, in_data, in_off, in_dir, in_auto, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_mask, out_clip
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data, in_off, in_dir, in_auto, in_last, out_ready,
        output in_ready, out_valid, out_data, out_mask, out_clip
    );
endinterface

// File: rtl/dyn_slice_packer.sv
// Packs SLICE-bit beats into a WIDTH-bit word at runtime offsets (+: or -:), clipping out-of-range bits.
// Latency: word is valid the cycle after the completing beat is accepted.
// Backpressure: in_ready drops while a finished word waits; it returns the cycle after out_ready takes it.
module dyn_slice_packer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int OFFW  = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    dyn_slice_packer_if.slave  bus
);
    // Two extra bits: one for the sign, one for headroom past 2**OFFW + SLICE.
    localparam int IW = OFFW + 2;
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic signed [IW-1:0] W_S  = IW'(WIDTH);
    localparam logic signed [IW-1:0] W_M1 = IW'(WIDTH - 1);
    localparam logic signed [IW-1:0] S_M1 = IW'(SLICE - 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t                 state, state_nx;
    logic [WIDTH-1:0]       acc, acc_nx;
    logic [WIDTH-1:0]       mask, mask_nx;
    logic                   clip, clip_nx;
    logic [OFFW-1:0]        ptr, ptr_nx;
    logic [OFFW:0]          ptr_sum;
    logic signed [IW-1:0]   eff, base, idx;
    logic                   fire;
    logic                   done;

    assign fire         = bus.in_valid && bus.in_ready;
    assign bus.out_data = acc;
    assign bus.out_mask = mask;
    assign bus.out_clip = clip;

    // Merge the incoming beat into the word: resolve offset, scatter bits, clip and advance pointer.
    always_comb begin
        acc_nx  = acc;
        mask_nx = mask;
        clip_nx = clip;
        ptr_nx  = ptr;
        idx     = '0;
        ptr_sum = {1'b0, ptr} + (OFFW+1)'(SLICE);

        if (!bus.in_auto)
            eff = $signed({2'b00, bus.in_off});
        else if (!bus.in_dir)
            eff = $signed({2'b00, ptr});
        else
            eff = W_M1 - $signed({2'b00, ptr});

        // Descending mode places the top beat bit at eff, like a -: select.
        base = bus.in_dir ? (eff - S_M1) : eff;

        for (int i = 0; i < SLICE; i++) begin
            idx = base + IW'(i);
            if (!idx[IW-1] && (idx < W_S)) begin
                acc_nx[idx[AW-1:0]]  = bus.in_data[i];
                mask_nx[idx[AW-1:0]] = 1'b1;
            end else begin
                clip_nx = 1'b1;
            end
        end

        if (bus.in_auto)
            ptr_nx = (ptr_sum > (OFFW+1)'(WIDTH)) ? OFFW'(WIDTH) : ptr_sum[OFFW-1:0];

        done = (&mask_nx) || bus.in_last;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ACC;
        else
            state <= state_nx;
    end

    // Next state and handshake outputs; no accept while reset is asserted.
    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ACC: begin
                bus.in_ready = !rst;
                if (fire && done)
                    state_nx = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_nx = ACC;
            end
            default: state_nx = ACC;
        endcase
    end

    // Word accumulator: load on accepted beats, clear once the held word is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            mask <= '0;
            clip <= 1'b0;
            ptr  <= '0;
        end else if (fire) begin
            acc  <= acc_nx;
            mask <= mask_nx;
            clip <= clip_nx;
            ptr  <= ptr_nx;
        end else if (bus.out_valid && bus.out_ready) begin
            acc  <= '0;
            mask <= '0;
            clip <= 1'b0;
            ptr  <= '0;
        end
    end
endmodule
